// File: rtl/mm_access_ctrl_pkg.sv
// mm_pkg: shared types and default constants for the main-memory access
// controller (state encoding, request latch layout, range-check helper).
package mm_pkg;

   localparam int unsigned MM_ADDR_WIDTH  = 10;
   localparam int unsigned MM_DATA_WIDTH  = 32;
   localparam int unsigned MM_BLOCK_COUNT = 1024;
   localparam int unsigned MM_TIMER_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      ACCESS  = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } mm_state_e;

   typedef struct packed {
      logic                     we;
      logic [MM_ADDR_WIDTH-1:0] addr;
      logic [MM_DATA_WIDTH-1:0] wdata;
   } mm_req_t;

   // Address compared at 32 bits so a block count equal to 2**ADDR_WIDTH
   // simply never flags an error.
   function automatic logic mm_addr_is_err(input logic [31:0] addr,
                                           input int unsigned block_count);
      return (addr >= block_count);
   endfunction

endpackage

// File: rtl/mm_access_ctrl_latency_timer.sv
// mm_latency_timer: loadable down-counter that paces the memory access.
// done_o flags the last wait cycle (count == 1); the counter parks at zero.
module mm_latency_timer #(
   parameter int unsigned WIDTH = mm_pkg::MM_TIMER_WIDTH
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // load wins over decrement; decrement stops at zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // count register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/mm_access_ctrl.sv
// mm_access_ctrl: one-at-a-time block read/write engine between the cache
// controller and a synchronous single-port memory. Fixed access latency,
// out-of-range addresses answered with an error and never strobed.
// Optional response statistics counters: define MM_ACCESS_STATS_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a request; latch it on handshake
// WAIT    | latency timer running down
// ACCESS  | single-cycle memory strobe
// CAPTURE | memory read data registered into the response
// RESP    | response held until the consumer takes it
module mm_access_ctrl #(
   parameter int unsigned MM_BLOCK_COUNT = mm_pkg::MM_BLOCK_COUNT,
   parameter int unsigned ADDR_WIDTH     = mm_pkg::MM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = mm_pkg::MM_DATA_WIDTH,
   parameter int unsigned ACCESS_LATENCY = 4,
   parameter int unsigned STAT_WIDTH     = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef MM_ACCESS_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] stat_reads_o,
   output logic [STAT_WIDTH-1:0] stat_writes_o,
   output logic [STAT_WIDTH-1:0] stat_errors_o
`endif
);

   import mm_pkg::*;

   localparam int unsigned TIMER_W = MM_TIMER_WIDTH;

   // elaboration-time parameter sanity
   if ((ACCESS_LATENCY < 1) || (ACCESS_LATENCY > 255)) begin : g_bad_latency
      $error("mm_access_ctrl: ACCESS_LATENCY must be 1..255");
   end
   if (STAT_WIDTH < 1) begin : g_bad_stat_width
      $error("mm_access_ctrl: STAT_WIDTH must be at least 1");
   end
   if ((ADDR_WIDTH != MM_ADDR_WIDTH) || (DATA_WIDTH != MM_DATA_WIDTH)) begin : g_bad_width
      $error("mm_access_ctrl: request latch layout fixed by mm_req_t widths");
   end

   mm_state_e             state_q, state_d;
   mm_req_t               req_q, req_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  tmr_load, tmr_dec, tmr_done;

   mm_latency_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (tmr_load),
      .load_val_i (TIMER_W'(ACCESS_LATENCY)),
      .dec_i      (tmr_dec),
      .done_o     (tmr_done)
   );

   // next-state, request latch/response updates and handshake/strobe outputs
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               req_d.we    = req_we_i;
               req_d.addr  = req_addr_i;
               req_d.wdata = req_wdata_i;
               rdata_d     = '0;
               err_d       = mm_addr_is_err(32'(req_addr_i), MM_BLOCK_COUNT);
               if (err_d) begin
                  state_d = RESP;
               end else begin
                  tmr_load = 1'b1;
                  state_d  = WAIT;
               end
            end
         end

         WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_done) begin
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            mem_en_o = 1'b1;
            mem_we_o = req_q.we;
            state_d  = req_q.we ? RESP : CAPTURE;
         end

         CAPTURE: begin
            rdata_d = mem_rdata_i;
            state_d = RESP;
         end

         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset drops any pending transaction
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr_o   = req_q.addr;
   assign mem_wdata_o  = req_q.wdata;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

`ifdef MM_ACCESS_STATS_EN
   logic [STAT_WIDTH-1:0] stat_reads_q, stat_writes_q, stat_errors_q;
   logic                  resp_hs;

   assign resp_hs = (state_q == RESP) && resp_ready_i;

   // saturating per-type response counters; an error counts only as an error
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
         stat_errors_q <= '0;
      end else if (resp_hs) begin
         if (err_q) begin
            if (stat_errors_q != '1) stat_errors_q <= stat_errors_q + STAT_WIDTH'(1);
         end else if (req_q.we) begin
            if (stat_writes_q != '1) stat_writes_q <= stat_writes_q + STAT_WIDTH'(1);
         end else begin
            if (stat_reads_q != '1) stat_reads_q <= stat_reads_q + STAT_WIDTH'(1);
         end
      end
   end

   assign stat_reads_o  = stat_reads_q;
   assign stat_writes_o = stat_writes_q;
   assign stat_errors_o = stat_errors_q;
`endif

endmodule

// File: tb/tb_mm_access_ctrl.sv
// tb_mm_access_ctrl: directed plus randomized transactions against a
// reference memory image and latency/counter rules kept in the bench.
module tb_mm_access_ctrl;

   localparam int L      = 4;
   localparam int BLOCKS = 1000;
   localparam int SW     = 2;
   localparam int SMAX   = (1 << SW) - 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef MM_ACCESS_STATS_EN
   logic [SW-1:0] stat_reads, stat_writes, stat_errors;
`endif

   mm_access_ctrl #(
      .MM_BLOCK_COUNT (BLOCKS),
      .ADDR_WIDTH     (10),
      .DATA_WIDTH     (32),
      .ACCESS_LATENCY (L),
      .STAT_WIDTH     (SW)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
`ifdef MM_ACCESS_STATS_EN
      ,
      .stat_reads_o  (stat_reads),
      .stat_writes_o (stat_writes),
      .stat_errors_o (stat_errors)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory array the controller drives (environment, not the reference)
   logic [31:0] tb_mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'(i);
   end
   always @(posedge clk) begin
      if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
   end

   // strobe monitor
   int          strobe_cnt = 0;
   int          strobe_cyc = 0;
   logic        strobe_we;
   logic [9:0]  strobe_addr;
   logic [31:0] strobe_wdata;
   always @(negedge clk) begin
      if (mem_en) begin
         strobe_cnt   = strobe_cnt + 1;
         strobe_cyc   = cyc;
         strobe_we    = mem_we;
         strobe_addr  = mem_addr;
         strobe_wdata = mem_wdata;
      end
   end

   // reference model
   logic [31:0] ref_mem [0:1023];
   int exp_reads = 0, exp_writes = 0, exp_errors = 0;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef MM_ACCESS_STATS_EN
      check("rst_stat_reads", 32'(stat_reads), 32'd0);
      check("rst_stat_writes", 32'(stat_writes), 32'd0);
      check("rst_stat_errors", 32'(stat_errors), 32'd0);
`endif
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic run_txn(input logic we, input int addr, input logic [31:0] wdata, input int hold);
      int n, acc, s0, exp_cyc;
      logic err;
      logic [31:0] exp_rd;
      err     = (addr >= BLOCKS);
      exp_rd  = (!we && !err) ? ref_mem[addr] : 32'h0;
      exp_cyc = err ? 1 : (we ? L + 2 : L + 3);

      wait_ready();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = 10'(addr);
      req_wdata = wdata;
      acc       = cyc;
      s0        = strobe_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = 10'($urandom);
      req_wdata = $urandom;

      n = 0;
      while (!resp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("resp_cycle", 32'(cyc - acc), 32'(exp_cyc));
      check("resp_err", 32'(resp_err), 32'(err));
      check("resp_rdata", resp_rdata, exp_rd);
      check("req_ready_busy", 32'(req_ready), 32'd0);

      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, exp_rd);
         check("hold_err", 32'(resp_err), 32'(err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end

      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("req_ready_after", 32'(req_ready), 32'd1);
      check("resp_valid_after", 32'(resp_valid), 32'd0);

      if (err) begin
         check("strobe_count_err", 32'(strobe_cnt - s0), 32'd0);
      end else begin
         check("strobe_count", 32'(strobe_cnt - s0), 32'd1);
         check("strobe_cycle", 32'(strobe_cyc - acc), 32'(L + 1));
         check("strobe_we", 32'(strobe_we), 32'(we));
         check("strobe_addr", 32'(strobe_addr), 32'(addr));
         if (we) check("strobe_wdata", strobe_wdata, wdata);
      end

      if (!err && we) ref_mem[addr] = wdata;
      if (err) begin
         if (exp_errors < SMAX) exp_errors++;
      end else if (we) begin
         if (exp_writes < SMAX) exp_writes++;
      end else begin
         if (exp_reads < SMAX) exp_reads++;
      end
   endtask

   task automatic check_stats();
`ifdef MM_ACCESS_STATS_EN
      check("stat_reads", 32'(stat_reads), 32'(exp_reads));
      check("stat_writes", 32'(stat_writes), 32'(exp_writes));
      check("stat_errors", 32'(stat_errors), 32'(exp_errors));
`endif
   endtask

   initial begin
      int s0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      @(negedge clk);

      // directed cases
      run_txn(1'b0, 10, 32'h0, 0);
      run_txn(1'b1, 3, 32'hDEADBEEF, 0);
      run_txn(1'b0, 3, 32'h0, 0);
      run_txn(1'b0, 1020, 32'h0, 0);
      run_txn(1'b0, BLOCKS - 1, 32'h0, 0);
      run_txn(1'b0, BLOCKS, 32'h0, 1);
      run_txn(1'b0, 7, 32'h0, 10);
      check_stats();

      // reset during WAIT of a write to addr 5
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 10'd5;
      req_wdata = 32'h12345678;
      s0        = strobe_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      exp_reads  = 0;
      exp_writes = 0;
      exp_errors = 0;
      repeat (10) @(negedge clk);
      check("reset_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      check("reset_mem5_kept", tb_mem[5], ref_mem[5]);
      run_txn(1'b0, 5, 32'h0, 0);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         int   a;
         logic w;
         if ($urandom_range(0, 5) == 0) a = $urandom_range(BLOCKS, 1023);
         else                           a = $urandom_range(0, 15);
         w = 1'($urandom_range(0, 1));
         run_txn(w, a, $urandom, $urandom_range(0, 3));
      end
      check_stats();

      for (int i = 0; i < 16; i++) check("mem_image", tb_mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
